// File: rtl/synaptic_current_accumulator.sv
// synaptic_current_accumulator: per-window weighted spike sum, serially scanned, integrated into a Q16.16 current.
// Define SYN_DECAY_EN for leaky integration; otherwise each window's sum replaces the previous one.
module synaptic_current_accumulator #(
    parameter int N_INPUTS    = 8,
    parameter int TICK_DIV    = 16,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_INPUTS-1:0]         spike_in,
    input  logic                        w_wr_en,
    input  logic [$clog2(N_INPUTS)-1:0] w_wr_addr,
    input  logic signed [31:0]          w_wr_data,
    input  logic signed [31:0]          I_bias,
    output logic signed [31:0]          I_out,
    output logic                        tick_out,
    output logic                        sat_out,
    input  logic                        sat_clr
);
    localparam int AW = $clog2(N_INPUTS);
    localparam int SW = 32 + AW + 1;
    localparam int CW = $clog2(TICK_DIV);

    if (N_INPUTS < 2 || TICK_DIV < N_INPUTS + 2 || DECAY_SHIFT < 0 || DECAY_SHIFT > 31) begin : g_bad_params
        $error("synaptic_current_accumulator: need N_INPUTS>=2, TICK_DIV>=N_INPUTS+2, 0<=DECAY_SHIFT<=31");
    end

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt;
    logic [N_INPUTS-1:0]   pending, snap;
    logic [AW-1:0]         idx;
    logic signed [SW-1:0]  acc, acc_add, s1, sum;
    logic signed [31:0]    w [N_INPUTS];
    logic signed [31:0]    syn_n, out_n;
    logic                  tick, snap_now, clamp;

    function automatic logic signed [SW-1:0] sx(input logic signed [31:0] v);
        return {{(SW-32){v[31]}}, v};
    endfunction

    // Out of 32-bit range when the bits above bit 31 are not a pure sign extension.
    function automatic logic ovf(input logic signed [SW-1:0] v);
        return !((&v[SW-1:31]) || !(|v[SW-1:31]));
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [SW-1:0] v);
        return ovf(v) ? (v[SW-1] ? 32'sh80000000 : 32'sh7FFFFFFF) : v[31:0];
    endfunction

    assign tick     = cnt == CW'(TICK_DIV - 1);
    assign snap_now = state == IDLE && tick;
    assign acc_add  = snap[idx] ? sx(w[idx]) : '0;

`ifdef SYN_DECAY_EN
    logic signed [31:0] syn;

    assign s1 = sx(syn) - sx(syn >>> DECAY_SHIFT) + acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) syn <= '0;
        else if (state == COMMIT) syn <= syn_n;
    end
`else
    assign s1 = acc;
`endif

    assign syn_n = sat32(s1);
    assign sum   = sx(syn_n) + sx(I_bias);
    assign out_n = sat32(sum);
    assign clamp = ovf(s1) || ovf(sum);

    always_comb begin
        state_d = state;
        state_d = snap_now ? SCAN
                : (state == SCAN && idx == AW'(N_INPUTS - 1)) ? COMMIT
                : (state == COMMIT) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pending  <= '0;
            snap     <= '0;
            idx      <= '0;
            acc      <= '0;
            I_out    <= '0;
            tick_out <= 1'b0;
            sat_out  <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) w[i] <= '0;
        end else begin
            state    <= state_d;
            cnt      <= tick ? '0 : cnt + 1'b1;
            pending  <= snap_now ? spike_in : pending | spike_in;
            snap     <= snap_now ? pending : snap;
            idx      <= (state == SCAN) ? idx + 1'b1 : '0;
            acc      <= (state == SCAN) ? acc + acc_add : snap_now ? '0 : acc;
            tick_out <= state == COMMIT;
            sat_out  <= (state == COMMIT && clamp) || (sat_out && !sat_clr);
            if (state == COMMIT) I_out <= out_n;
            if (w_wr_en) w[w_wr_addr] <= w_wr_data;
        end
    end
endmodule
